cic_decim_param: RTL and testbench

Parametrised CIC decimation filter and the next generation of the fixed 8-bit CIC in the filter chain. Stage count, data width and maximum decimation are compile-time parameters; the decimation ratio R = 2^k is selected at run time. The gain R^N is normalised by an exact right shift, so the output has the input width. It sits between the sample source (data_in / data_in_ready) and the FIR stage, which consumes cic_data_out / cic_out_ready.

---
 rtl/cic_pkg.sv | 24 ++
 rtl/cic_stage.sv | 47 ++++
 rtl/cic_decim_param.sv | 151 +++++++++++++++
 tb/tb_cic_decim_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared sizing helpers and legal parameter ranges for the parametrised CIC decimator.
// CIC_ROUND_EN (used by cic_decim_param) selects round-half-up with saturation at the output.
package cic_pkg;

  localparam int STAGES_MIN       = 1;
  localparam int STAGES_MAX       = 6;
  localparam int MAX_DEC_LOG2_MIN = 1;
  localparam int MAX_DEC_LOG2_MAX = 8;

  // Worst-case growth is R^N, so the accumulators need N*log2(Rmax) extra bits.
  function automatic int cic_acc_w(input int data_w, input int stages, input int max_dec_log2);
    return data_w + stages * max_dec_log2;
  endfunction

  function automatic int cic_k_w(input int max_dec_log2);
    return $clog2(max_dec_log2 + 1);
  endfunction

  function automatic bit cic_params_ok(input int stages, input int max_dec_log2);
    return (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
           (max_dec_log2 >= MAX_DEC_LOG2_MIN) && (max_dec_log2 <= MAX_DEC_LOG2_MAX);
  endfunction

endpackage

// File: rtl/cic_stage.sv
// One integrator/comb pair of the CIC chain; all arithmetic wraps at ACC_W bits.
// The comb difference is combinational so a whole comb column settles in the decimation cycle.
module cic_stage
  import cic_pkg::*;
#(
  parameter int ACC_W = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             integ_en,
  input  logic [ACC_W-1:0] integ_in,
  input  logic             comb_en,
  input  logic [ACC_W-1:0] comb_in,
  output logic [ACC_W-1:0] integ_out,
  output logic [ACC_W-1:0] comb_out
);

  logic [ACC_W-1:0] integ_q, integ_d;
  logic [ACC_W-1:0] delay_q, delay_d;

  always_comb begin
    integ_d = integ_q;
    delay_d = delay_q;
    if (clear) begin
      integ_d = '0;
      delay_d = '0;
    end else begin
      if (integ_en) integ_d = integ_q + integ_in;
      if (comb_en)  delay_d = comb_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      integ_q <= '0;
      delay_q <= '0;
    end else begin
      integ_q <= integ_d;
      delay_q <= delay_d;
    end
  end

  assign integ_out = integ_q;
  assign comb_out  = comb_in - delay_q;

endmodule

// File: rtl/cic_decim_param.sv
// Parametrised CIC decimator, R = 2^k chosen at clear time, gain removed by a right shift of N*k.
// Define CIC_ROUND_EN for round-half-up plus output saturation; otherwise floor and truncate.
module cic_decim_param
  import cic_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int STAGES       = 3,
  parameter int MAX_DEC_LOG2 = 3
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 clear,
  input  logic [DATA_W-1:0]                    data_in,
  input  logic                                 data_in_ready,
  input  logic [$clog2(MAX_DEC_LOG2+1)-1:0]    filter_dec_factor,
  output logic [DATA_W-1:0]                    cic_data_out,
  output logic                                 cic_out_ready
);

  localparam int ACC_W = cic_acc_w(DATA_W, STAGES, MAX_DEC_LOG2);
  localparam int KW    = cic_k_w(MAX_DEC_LOG2);
  localparam int SH_W  = $clog2(STAGES * MAX_DEC_LOG2 + 1);

  if (!cic_params_ok(STAGES, MAX_DEC_LOG2)) begin : g_param_check
    $error("cic_decim_param: STAGES or MAX_DEC_LOG2 outside the supported range");
  end

  logic [KW-1:0]           k_q, k_d;
  logic [MAX_DEC_LOG2-1:0] cnt_q, cnt_d;
  logic [MAX_DEC_LOG2-1:0] blk_last;
  logic                    dec_q, dec_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    strobe_q, strobe_d;
  logic [DATA_W-1:0]       scaled;
  logic [SH_W-1:0]         shamt;
  logic                    integ_en;
  logic                    comb_en;

  logic [ACC_W-1:0] integ [STAGES];
  logic [ACC_W-1:0] comb  [STAGES+1];
  logic [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-DATA_W){data_in[DATA_W-1]}}, data_in};
  assign integ_en   = data_in_ready & ~clear;
  assign comb_en    = dec_q & ~clear;

  // Factor is only sampled while clear is high so R never changes mid-block.
  always_comb begin
    k_d = k_q;
    if (clear) begin
      if (filter_dec_factor > KW'(MAX_DEC_LOG2)) k_d = KW'(MAX_DEC_LOG2);
      else                                       k_d = filter_dec_factor;
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_DEC_LOG2; i++) blk_last[i] = (i < int'(k_q));
  end

  always_comb begin
    cnt_d = cnt_q;
    dec_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (data_in_ready) begin
      if (cnt_q == blk_last) begin
        cnt_d = '0;
        dec_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign comb[0] = integ[STAGES-1];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [ACC_W-1:0] stage_in;
    if (g == 0) begin : g_first
      assign stage_in = sample_ext;
    end else begin : g_rest
      assign stage_in = integ[g-1];
    end
    cic_stage #(.ACC_W(ACC_W)) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .integ_en  (integ_en),
      .integ_in  (stage_in),
      .comb_en   (comb_en),
      .comb_in   (comb[g]),
      .integ_out (integ[g]),
      .comb_out  (comb[g+1])
    );
  end

  assign shamt = SH_W'(STAGES * int'(k_q));

`ifdef CIC_ROUND_EN
  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] rnd_sum;
  logic signed [ACC_W:0] rnd_shift;

  // One guard bit keeps the rounding add from wrapping near full scale.
  always_comb begin
    half = '0;
    if (shamt != '0) half = {{ACC_W{1'b0}}, 1'b1} << (shamt - SH_W'(1));
    rnd_sum   = signed'({comb[STAGES][ACC_W-1], comb[STAGES]}) + half;
    rnd_shift = rnd_sum >>> shamt;
    if (rnd_shift > OUT_MAX)      scaled = DATA_W'(OUT_MAX);
    else if (rnd_shift < OUT_MIN) scaled = DATA_W'(OUT_MIN);
    else                          scaled = DATA_W'(rnd_shift);
  end
`else
  logic signed [ACC_W-1:0] comb_last;
  assign comb_last = signed'(comb[STAGES]);
  assign scaled    = DATA_W'(comb_last >>> shamt);
`endif

  always_comb begin
    dout_d   = dout_q;
    strobe_d = 1'b0;
    if (!clear && dec_q) begin
      dout_d   = scaled;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q      <= '0;
      cnt_q    <= '0;
      dec_q    <= 1'b0;
      dout_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      dec_q    <= dec_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
    end
  end

  assign cic_data_out  = dout_q;
  assign cic_out_ready = strobe_q;

endmodule

// File: tb/tb_cic_decim_param.sv
// Directed bench for cic_decim_param: a convolution model of the CIC response feeds an
// expected-value queue that is checked against every output strobe (value and cycle).
module tb_cic_decim_param;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic [7:0] data_in;
  logic       data_in_ready;
  logic [1:0] filter_dec_factor;
  logic [7:0] cic_data_out;
  logic       cic_out_ready;

  cic_decim_param #(.DATA_W(8), .STAGES(3), .MAX_DEC_LOG2(3)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .clear             (clear),
    .data_in           (data_in),
    .data_in_ready     (data_in_ready),
    .filter_dec_factor (filter_dec_factor),
    .cic_data_out      (cic_data_out),
    .cic_out_ready     (cic_out_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  // ---------------- scoreboard state ----------------
  int         pass_cnt = 0;
  int         chk_cnt  = 0;
  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  int         hist[$];
  int         k_model  = 0;
  int         blk_cnt  = 0;
  int         strobes  = 0;
  logic [7:0] last_out = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Output = ((1-z^-R)/(1-z^-1))^N applied to the samples, delayed N-1 by the registered
  // integrator cascade, divided by R^N.
  function automatic logic [7:0] model_out();
    int     r;
    int     h[$];
    int     nh[$];
    int     n;
    int     sh;
    longint acc;
    r = 1 << k_model;
    h = {1};
    for (int s = 0; s < N; s++) begin
      nh.delete();
      for (int i = 0; i < h.size() + r - 1; i++) begin
        int v = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) v += h[i-j];
        nh.push_back(v);
      end
      h = nh;
    end
    n   = hist.size() - 1;
    acc = 0;
    for (int j = 0; j < h.size(); j++) begin
      int idx = n - (N - 1) - j;
      if (idx >= 0) acc += longint'(h[j]) * longint'(hist[idx]);
    end
    sh = N * k_model;
`ifdef CIC_ROUND_EN
    if (sh > 0) acc += longint'(1) << (sh - 1);
    acc = acc >>> sh;
    if (acc > 127)  acc = 127;
    if (acc < -128) acc = -128;
`else
    acc = acc >>> sh;
`endif
    return acc[7:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input int x);
    data_in       = x[7:0];
    data_in_ready = 1'b1;
    @(posedge clk);
    #1;
    data_in_ready = 1'b0;
    hist.push_back(x);
    blk_cnt++;
    if (blk_cnt == (1 << k_model)) begin
      blk_cnt = 0;
      exp_q.push_back(model_out());
      exp_cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input int k, input bit with_valid, input int x);
    clear             = 1'b1;
    filter_dec_factor = k[1:0];
    data_in_ready     = with_valid;
    data_in           = x[7:0];
    @(posedge clk);
    #1;
    clear         = 1'b0;
    data_in_ready = 1'b0;
    hist.delete();
    blk_cnt = 0;
    k_model = (k > 3) ? 3 : k;
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && cic_out_ready) begin
      strobes++;
      last_out = cic_data_out;
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $error("FAIL unexpected_strobe: observed data %0h at cycle %0d expected no strobe", cic_data_out, cyc);
      end else begin
        logic [7:0] ev;
        int         ec;
        ev = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("out_value", cic_data_out, ev);
        check("out_cycle", cyc, ec);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int v;
    reset_n           = 1'b0;
    clear             = 1'b0;
    data_in           = '0;
    data_in_ready     = 1'b0;
    filter_dec_factor = '0;
    idle(3);
    check("reset_ready", cic_out_ready, 1'b0);
    check("reset_data", cic_data_out, 8'h00);
    reset_n = 1'b1;
    idle(2);

    // k=2, constant 20
    do_clear(2, 1'b0, 0);
    for (int i = 0; i < 40; i++) send(20);
    drain("k2_const20_drain");
    check("k2_const20_final", last_out, 8'd20);

    // k=3, full-scale negative and positive
    do_clear(3, 1'b0, 0);
    for (int i = 0; i < 64; i++) send(-128);
    drain("k3_neg_drain");
    check("k3_neg_final", last_out, 8'h80);
    do_clear(3, 1'b0, 0);
    for (int i = 0; i < 64; i++) send(127);
    drain("k3_pos_drain");
    check("k3_pos_final", last_out, 8'h7f);

    // k=0 ramp, strobe every cycle
    do_clear(0, 1'b0, 0);
    s0 = strobes;
    for (int i = 0; i < 30; i++) send(i);
    drain("k0_ramp_drain");
    check("k0_ramp_strobes", strobes - s0, 30);

    // k=2, constant -1 and alternating 1/2
    do_clear(2, 1'b0, 0);
    for (int i = 0; i < 40; i++) send(-1);
    drain("k2_neg1_drain");
    check("k2_neg1_final", last_out, 8'hff);
    do_clear(2, 1'b0, 0);
    for (int i = 0; i < 40; i++) send((i % 2 == 0) ? 1 : 2);
    drain("k2_alt_drain");
`ifdef CIC_ROUND_EN
    check("k2_alt_final", last_out, 8'd2);
`else
    check("k2_alt_final", last_out, 8'd1);
`endif

    // clear mid-block with a valid sample; factor change without clear ignored
    do_clear(2, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(100, 0)) - 50;
      send(v);
    end
    idle(3);
    s0 = strobes;
    do_clear(2, 1'b1, 77);
    filter_dec_factor = 2'd0;
    for (int i = 0; i < 3; i++) begin
      v = int'($urandom_range(100, 0)) - 50;
      send(v);
    end
    idle(3);
    check("clear_no_strobe", strobes - s0, 0);
    send(33);
    idle(3);
    check("clear_next_strobe", strobes - s0, 1);
    for (int i = 0; i < 8; i++) send(i * 5 - 20);
    drain("clear_drain");
    check("clear_k_kept", strobes - s0, 3);

    // reset mid-stream at k=1
    do_clear(1, 1'b0, 0);
    for (int i = 0; i < 9; i++) send(i * 3);
    data_in       = 8'd40;
    data_in_ready = 1'b1;
    @(posedge clk);
    #1;
    reset_n       = 1'b0;
    data_in_ready = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check("midrst_ready", cic_out_ready, 1'b0);
    check("midrst_data", cic_data_out, 8'h00);
    idle(2);
    reset_n           = 1'b1;
    filter_dec_factor = 2'd3;
    hist.delete();
    blk_cnt = 0;
    k_model = 0;
    s0      = strobes;
    for (int i = 0; i < 6; i++) send(10 + i);
    drain("post_rst_drain");
    check("post_rst_strobes", strobes - s0, 6);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
